// File: rtl/bus_pend_rr_scan.sv
// Round-robin scanner over a pending-flag vector: picks one bus, hands it to the consumer
// via req/ack, then strobes a clear back to the pending register.
module bus_pend_rr_scan #(
   parameter int unsigned N_BUS       = 32,
   parameter int unsigned SEL_W       = 5,
   parameter int unsigned TIMEOUT_CYC = 256
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic [N_BUS-1:0] i_pend_in,
   input  logic             i_scan_en,
   input  logic             i_grant_ack,
   output logic             o_req,
   output logic [SEL_W-1:0] o_bus_sel,
   output logic             o_clr_pulse,
   output logic [SEL_W-1:0] o_clr_sel,
   output logic             o_timeout,
   output logic             o_busy
);

   typedef enum logic [1:0] {StIdle, StScan, StReq, StClear} state_e;

   state_e           r_state;
   logic             r_req;
   logic [SEL_W-1:0] r_bus_sel;
   logic             r_clr_pulse;
   logic [SEL_W-1:0] r_clr_sel;
   logic             r_timeout;
   logic             r_busy;
   logic [SEL_W-1:0] r_last_ptr;
   logic [15:0]      r_cnt;

   logic             w_found;
   logic [SEL_W-1:0] w_pick;

   // First pending bus at or after last_ptr+1, wrapping modulo N_BUS.
   always_comb begin
      w_found = 1'b0;
      w_pick  = '0;
      for (int unsigned i = 0; i < N_BUS; i++) begin
         int unsigned idx;
         idx = (32'(r_last_ptr) + 32'd1 + i) % N_BUS;
         if (!w_found && i_pend_in[SEL_W'(idx)]) begin
            w_found = 1'b1;
            w_pick  = SEL_W'(idx);
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state     <= StIdle;
         r_req       <= 1'b0;
         r_bus_sel   <= '0;
         r_clr_pulse <= 1'b0;
         r_clr_sel   <= '0;
         r_timeout   <= 1'b0;
         r_busy      <= 1'b0;
         r_last_ptr  <= SEL_W'(N_BUS - 1);
         r_cnt       <= '0;
      end else begin
         r_clr_pulse <= 1'b0;
         r_timeout   <= 1'b0;
         unique case (r_state)
            StIdle: begin
               if (i_scan_en && |i_pend_in) begin
                  r_state <= StScan;
                  r_busy  <= 1'b1;
               end
            end
            StScan: begin
               if (w_found) begin
                  r_bus_sel <= w_pick;
                  r_req     <= 1'b1;
                  r_cnt     <= '0;
                  r_state   <= StReq;
               end else begin
                  r_busy  <= 1'b0;
                  r_state <= StIdle;
               end
            end
            StReq: begin
               // Ack takes priority over a coincident timeout.
               if (i_grant_ack) begin
                  r_req       <= 1'b0;
                  r_clr_pulse <= 1'b1;
                  r_clr_sel   <= r_bus_sel;
                  r_state     <= StClear;
               end else if (TIMEOUT_CYC != 0 && r_cnt == 16'(TIMEOUT_CYC - 1)) begin
                  r_req      <= 1'b0;
                  r_timeout  <= 1'b1;
                  r_last_ptr <= r_bus_sel;
                  r_cnt      <= '0;
                  r_busy     <= 1'b0;
                  r_state    <= StIdle;
               end else if (r_cnt != 16'hFFFF) begin
                  r_cnt <= r_cnt + 16'd1;
               end
            end
            StClear: begin
               r_last_ptr <= r_bus_sel;
               r_cnt      <= '0;
               r_busy     <= 1'b0;
               r_state    <= StIdle;
            end
            default: r_state <= StIdle;
         endcase
      end
   end

   assign o_req       = r_req;
   assign o_bus_sel   = r_bus_sel;
   assign o_clr_pulse = r_clr_pulse;
   assign o_clr_sel   = r_clr_sel;
   assign o_timeout   = r_timeout;
   assign o_busy      = r_busy;

endmodule

// File: tb/tb_bus_pend_rr_scan.sv
// Scenario bench for bus_pend_rr_scan: expected bus indices are queued when stimulus is
// applied and popped when the DUT raises req.
module tb_bus_pend_rr_scan;

   localparam int unsigned N_BUS = 32;
   localparam int unsigned SEL_W = 5;

   logic             clk = 1'b0;
   logic             rst;
   logic [N_BUS-1:0] pend;
   logic             scan_en;
   logic             ack;
   logic             req;
   logic [SEL_W-1:0] bus_sel;
   logic             clr_pulse;
   logic [SEL_W-1:0] clr_sel;
   logic             timeout;
   logic             busy;

   int               n_vec = 0;
   int               n_err = 0;
   logic [SEL_W-1:0] q_exp[$];

   bus_pend_rr_scan #(
      .N_BUS      (N_BUS),
      .SEL_W      (SEL_W),
      .TIMEOUT_CYC(8)
   ) dut (
      .i_clk      (clk),
      .i_rst      (rst),
      .i_pend_in  (pend),
      .i_scan_en  (scan_en),
      .i_grant_ack(ack),
      .o_req      (req),
      .o_bus_sel  (bus_sel),
      .o_clr_pulse(clr_pulse),
      .o_clr_sel  (clr_sel),
      .o_timeout  (timeout),
      .o_busy     (busy)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic do_reset();
      rst = 1'b1;
      ack = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   // Bounded wait for req; returns at the first negedge where req is high.
   task automatic wait_req(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (req === 1'b1) begin
            ok = 1'b1;
            return;
         end
      end
   endtask

   task automatic test_reset();
      bit ok;
      logic [SEL_W-1:0] exp;
      rst = 1'b1; ack = 1'b0; scan_en = 1'b1; pend = 32'hFFFF_FFFF;
      repeat (2) @(posedge clk);
      @(negedge clk);
      n_vec++;
      if ({req, bus_sel, clr_pulse, clr_sel, timeout, busy} !== '0) begin
         n_err++;
         $display("FAIL reset_outputs: got req=%b sel=%0d clr=%b csel=%0d to=%b busy=%b, want 0",
                  req, bus_sel, clr_pulse, clr_sel, timeout, busy);
      end
      rst = 1'b0;
      q_exp.push_back(5'd0);
      wait_req(ok);
      n_vec++;
      if (!ok) begin n_err++; $display("FAIL reset_first_req: got no req, want req"); end
      exp = q_exp.pop_front();
      n_vec++;
      if (bus_sel !== exp) begin
         n_err++; $display("FAIL reset_first_sel: got %0d, want %0d", bus_sel, exp);
      end
      ack = 1'b1;
      @(negedge clk);
      ack = 1'b0;
      pend = '0;
      n_vec++;
      if (clr_pulse !== 1'b1 || clr_sel !== exp) begin
         n_err++; $display("FAIL reset_clear: got clr=%b csel=%0d, want 1/%0d", clr_pulse, clr_sel, exp);
      end
      @(negedge clk);
   endtask

   task automatic test_single();
      logic [SEL_W-1:0] exp;
      pend = '0; scan_en = 1'b1;
      do_reset();
      pend = 32'h0000_0001;
      q_exp.push_back(5'd0);
      @(negedge clk);
      n_vec++;
      if (req !== 1'b0 || busy !== 1'b1) begin
         n_err++; $display("FAIL single_scan: got req=%b busy=%b, want 0/1", req, busy);
      end
      @(negedge clk);
      exp = q_exp.pop_front();
      n_vec++;
      if (req !== 1'b1 || bus_sel !== exp) begin
         n_err++; $display("FAIL single_req_latency: got req=%b sel=%0d, want 1/%0d", req, bus_sel, exp);
      end
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         n_vec++;
         if (req !== 1'b1 || bus_sel !== exp || clr_pulse !== 1'b0) begin
            n_err++; $display("FAIL single_hold: got req=%b sel=%0d clr=%b, want 1/%0d/0",
                              req, bus_sel, clr_pulse, exp);
         end
      end
      ack = 1'b1;
      @(negedge clk);
      ack = 1'b0;
      pend = '0;
      n_vec++;
      if (clr_pulse !== 1'b1 || clr_sel !== exp || req !== 1'b0) begin
         n_err++; $display("FAIL single_clear: got clr=%b csel=%0d req=%b, want 1/%0d/0",
                           clr_pulse, clr_sel, req, exp);
      end
      @(negedge clk);
      n_vec++;
      if (clr_pulse !== 1'b0 || busy !== 1'b0) begin
         n_err++; $display("FAIL single_idle: got clr=%b busy=%b, want 0/0", clr_pulse, busy);
      end
   endtask

   task automatic test_round_robin();
      bit ok;
      logic [SEL_W-1:0] exp;
      pend = '0; scan_en = 1'b1;
      do_reset();
      pend = 32'h8000_0011;
      q_exp.push_back(5'd0); q_exp.push_back(5'd4); q_exp.push_back(5'd31); q_exp.push_back(5'd0);
      for (int t = 0; t < 4; t++) begin
         wait_req(ok);
         exp = q_exp.pop_front();
         n_vec++;
         if (!ok || bus_sel !== exp) begin
            n_err++; $display("FAIL rr_order[%0d]: got req=%b sel=%0d, want 1/%0d", t, ok, bus_sel, exp);
         end
         ack = 1'b1;
         @(negedge clk);
         ack = 1'b0;
         n_vec++;
         if (clr_pulse !== 1'b1 || clr_sel !== exp) begin
            n_err++; $display("FAIL rr_clear[%0d]: got clr=%b csel=%0d, want 1/%0d", t, clr_pulse, clr_sel, exp);
         end
         pend[exp] = 1'b0;
         if (t == 0) pend[0] = 1'b1;
      end
      @(negedge clk);
   endtask

   task automatic test_timeout();
      bit ok;
      bit saw_clr;
      int n_hi;
      logic [SEL_W-1:0] exp;
      pend = '0; scan_en = 1'b1;
      do_reset();
      pend = 32'h0000_0006;
      q_exp.push_back(5'd1);
      wait_req(ok);
      exp = q_exp.pop_front();
      n_vec++;
      if (!ok || bus_sel !== exp) begin
         n_err++; $display("FAIL to_first_sel: got req=%b sel=%0d, want 1/%0d", ok, bus_sel, exp);
      end
      n_hi = 1; saw_clr = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (clr_pulse === 1'b1) saw_clr = 1'b1;
         if (req === 1'b1) n_hi++;
         else break;
      end
      n_vec++;
      if (n_hi != 8 || timeout !== 1'b1 || saw_clr || clr_pulse !== 1'b0) begin
         n_err++; $display("FAIL to_pulse: got req_cycles=%0d to=%b clr_seen=%b, want 8/1/0",
                           n_hi, timeout, saw_clr | clr_pulse);
      end
      q_exp.push_back(5'd2);
      @(negedge clk);
      n_vec++;
      if (timeout !== 1'b0) begin
         n_err++; $display("FAIL to_one_cycle: got to=%b, want 0", timeout);
      end
      wait_req(ok);
      exp = q_exp.pop_front();
      n_vec++;
      if (!ok || bus_sel !== exp) begin
         n_err++; $display("FAIL to_next_sel: got req=%b sel=%0d, want 1/%0d", ok, bus_sel, exp);
      end
      ack = 1'b1;
      @(negedge clk);
      ack = 1'b0;
      pend = '0;
      n_vec++;
      if (clr_pulse !== 1'b1 || clr_sel !== exp) begin
         n_err++; $display("FAIL to_next_clear: got clr=%b csel=%0d, want 1/%0d", clr_pulse, clr_sel, exp);
      end
      @(negedge clk);
   endtask

   task automatic test_ack_at_timeout();
      bit ok;
      logic [SEL_W-1:0] exp;
      pend = '0; scan_en = 1'b1;
      do_reset();
      pend = 32'h0000_0002;
      q_exp.push_back(5'd1);
      wait_req(ok);
      exp = q_exp.pop_front();
      repeat (7) @(negedge clk);
      ack = 1'b1;
      @(negedge clk);
      ack = 1'b0;
      pend = '0;
      n_vec++;
      if (clr_pulse !== 1'b1 || clr_sel !== exp || timeout !== 1'b0) begin
         n_err++; $display("FAIL ack_wins: got clr=%b csel=%0d to=%b, want 1/%0d/0",
                           clr_pulse, clr_sel, timeout, exp);
      end
      @(negedge clk);
   endtask

   task automatic test_scan_en_off();
      bit ok;
      bit bad;
      logic [SEL_W-1:0] exp;
      pend = '0; scan_en = 1'b1;
      do_reset();
      pend = 32'h0000_0030;
      q_exp.push_back(5'd4);
      wait_req(ok);
      exp = q_exp.pop_front();
      scan_en = 1'b0;
      @(negedge clk);
      ack = 1'b1;
      @(negedge clk);
      ack = 1'b0;
      n_vec++;
      if (clr_pulse !== 1'b1 || clr_sel !== exp) begin
         n_err++; $display("FAIL scan_off_clear: got clr=%b csel=%0d, want 1/%0d", clr_pulse, clr_sel, exp);
      end
      pend[exp] = 1'b0;
      bad = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (busy !== 1'b0 || req !== 1'b0) bad = 1'b1;
      end
      n_vec++;
      if (bad) begin
         n_err++; $display("FAIL scan_off_idle: got busy/req activity=1, want 0");
      end
      pend = '0;
      scan_en = 1'b1;
   endtask

   task automatic test_reset_mid_req();
      bit ok;
      logic [SEL_W-1:0] exp;
      pend = '0; scan_en = 1'b1;
      do_reset();
      pend = 32'h0000_0080;
      q_exp.push_back(5'd7);
      wait_req(ok);
      exp = q_exp.pop_front();
      n_vec++;
      if (!ok || bus_sel !== exp) begin
         n_err++; $display("FAIL rst_mid_sel: got req=%b sel=%0d, want 1/%0d", ok, bus_sel, exp);
      end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      n_vec++;
      if (req !== 1'b0 || clr_pulse !== 1'b0 || busy !== 1'b0 || bus_sel !== 5'd0) begin
         n_err++; $display("FAIL rst_mid_abort: got req=%b clr=%b busy=%b sel=%0d, want 0/0/0/0",
                           req, clr_pulse, busy, bus_sel);
      end
      q_exp.push_back(5'd7);
      wait_req(ok);
      exp = q_exp.pop_front();
      n_vec++;
      if (!ok || bus_sel !== exp) begin
         n_err++; $display("FAIL rst_mid_resel: got req=%b sel=%0d, want 1/%0d", ok, bus_sel, exp);
      end
      ack = 1'b1;
      @(negedge clk);
      ack = 1'b0;
      pend = '0;
      @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_single();
      test_round_robin();
      test_timeout();
      test_ack_at_timeout();
      test_scan_en_off();
      test_reset_mid_req();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
